// File: rtl/dct_pkg.sv
// Shared constants and pair-tag encodings for the DCT row pair path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dct_pkg;
  localparam int ROW_LEN   = 8;
  localparam int PAIRS     = 4;
  localparam int SEL_W     = 2;
  localparam int IDX_W     = 3;
  localparam int DEF_WIDTH = 8;

  // Sele encodings, also decoded by the downstream 1-to-4 selector
  typedef enum logic [SEL_W-1:0] {
    SEL_P07 = 2'd0,
    SEL_P16 = 2'd1,
    SEL_P25 = 2'd2,
    SEL_P34 = 2'd3
  } sel_e;

  // Index of the mirrored partner sample within a row: k -> 7-k
  function automatic logic [IDX_W-1:0] mirror_idx(input logic [IDX_W-1:0] idx);
    return IDX_W'(ROW_LEN - 1) - idx;
  endfunction
endpackage

// File: rtl/dct_row_bank.sv
// One row buffer: 8 sample registers plus a full flag, two combinational read ports.
// Latency: write visible on read ports the cycle after the write edge.
// Backpressure: none locally; the owner gates writes with the full flag.
module dct_row_bank
  import dct_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_set_full,
  input  logic             i_clr_full,
  input  logic [IDX_W-1:0] i_lo_idx,
  input  logic [IDX_W-1:0] i_hi_idx,
  output logic [WIDTH-1:0] o_lo_dat,
  output logic [WIDTH-1:0] o_hi_dat,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [ROW_LEN];
  logic             r_full;

  // Sample storage; cleared on reset so an empty sequencer shows zeros
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < ROW_LEN; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_dat;
    end
  end

  // Full flag: set when the last sample lands, cleared when the last pair leaves
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)          r_full <= 1'b0;
    else if (i_set_full) r_full <= 1'b1;
    else if (i_clr_full) r_full <= 1'b0;
  end

  assign o_lo_dat = r_mem[i_lo_idx];
  assign o_hi_dat = r_mem[i_hi_idx];
  assign o_full   = r_full;

endmodule

// File: rtl/dct_row_pair_sequencer.sv
// Collects serial 8-sample rows into a ping-pong buffer and emits mirrored pairs tagged by Sele.
// Latency: first pair valid the cycle after the 8th sample is accepted.
// Backpressure: In_Ready drops while both banks hold complete rows; Out_Valid holds until Out_Ready.
module dct_row_pair_sequencer
  import dct_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ROWS_BLK = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Data_Lo,
  output logic [WIDTH-1:0] Data_Hi,
  output logic [SEL_W-1:0] Sele,
  output logic             Out_Row_Last,
  output logic             Out_Block_Last
);

  localparam int RC_W = (ROWS_BLK > 1) ? $clog2(ROWS_BLK) : 1;

  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [SEL_W-1:0] r_sele;
  logic [RC_W-1:0]  r_row_cnt;

  logic             w_full0, w_full1;
  logic [WIDTH-1:0] w_lo0, w_hi0, w_lo1, w_hi1;
  logic [IDX_W-1:0] w_lo_idx, w_hi_idx;
  logic             w_in_acc, w_out_acc, w_row_done, w_pair_last, w_drain_done;

  assign w_in_acc     = In_Valid && In_Ready;
  assign w_out_acc    = Out_Valid && Out_Ready;
  assign w_row_done   = w_in_acc && (r_wr_idx == IDX_W'(ROW_LEN - 1));
  assign w_pair_last  = (r_sele == SEL_P34);
  assign w_drain_done = w_out_acc && w_pair_last;
  assign w_lo_idx     = IDX_W'(r_sele);
  assign w_hi_idx     = mirror_idx(w_lo_idx);

  dct_row_bank #(.WIDTH(WIDTH)) u_bank0 (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .i_we       (w_in_acc && !r_wr_bank),
    .i_wr_idx   (r_wr_idx),
    .i_wr_dat   (In_Data),
    .i_set_full (w_row_done && !r_wr_bank),
    .i_clr_full (w_drain_done && !r_rd_bank),
    .i_lo_idx   (w_lo_idx),
    .i_hi_idx   (w_hi_idx),
    .o_lo_dat   (w_lo0),
    .o_hi_dat   (w_hi0),
    .o_full     (w_full0)
  );

  dct_row_bank #(.WIDTH(WIDTH)) u_bank1 (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .i_we       (w_in_acc && r_wr_bank),
    .i_wr_idx   (r_wr_idx),
    .i_wr_dat   (In_Data),
    .i_set_full (w_row_done && r_wr_bank),
    .i_clr_full (w_drain_done && r_rd_bank),
    .i_lo_idx   (w_lo_idx),
    .i_hi_idx   (w_hi_idx),
    .o_lo_dat   (w_lo1),
    .o_hi_dat   (w_hi1),
    .o_full     (w_full1)
  );

  // Write side: advance sample index, hop to the other bank after the 8th sample
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
    end else if (w_in_acc) begin
      if (w_row_done) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_idx  <= '0;
      end else begin
        r_wr_idx  <= r_wr_idx + 1'b1;
      end
    end
  end

  // Read side: step through the 4 pairs, then release the bank and count the row
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_bank <= 1'b0;
      r_sele    <= SEL_P07;
      r_row_cnt <= '0;
    end else if (w_out_acc) begin
      if (w_pair_last) begin
        r_rd_bank <= ~r_rd_bank;
        r_sele    <= SEL_P07;
        r_row_cnt <= (r_row_cnt == RC_W'(ROWS_BLK - 1)) ? '0 : r_row_cnt + 1'b1;
      end else begin
        r_sele    <= r_sele + 1'b1;
      end
    end
  end

  assign In_Ready       = r_wr_bank ? !w_full1 : !w_full0;
  assign Out_Valid      = r_rd_bank ? w_full1 : w_full0;
  assign Data_Lo        = r_rd_bank ? w_lo1 : w_lo0;
  assign Data_Hi        = r_rd_bank ? w_hi1 : w_hi0;
  assign Sele           = r_sele;
  assign Out_Row_Last   = Out_Valid && w_pair_last;
  assign Out_Block_Last = Out_Row_Last && (r_row_cnt == RC_W'(ROWS_BLK - 1));

endmodule
